// File: rtl/bp_me_nonsynth_lce_tr_driver.sv
// Trace-replay driver: walks a trace ROM, issues load/store packets to an LCE and checks load data.
// Define BP_ME_TR_DRIVER_TIMEOUT_EN to add a response watchdog that traps to the error state.
module bp_me_nonsynth_lce_tr_driver #(
    parameter int unsigned paddr_width_p    = 40,
    parameter int unsigned dword_width_p    = 64,
    parameter int unsigned rom_addr_width_p = 10,
    parameter int unsigned timeout_cycles_p = 4096,
    localparam int unsigned EntryWidth      = 5 + paddr_width_p + dword_width_p
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        en_i,
    output logic [rom_addr_width_p-1:0] rom_addr_o,
    input  logic [EntryWidth-1:0]       rom_data_i,
    output logic [EntryWidth-1:0]       tr_pkt_o,
    output logic                        tr_pkt_v_o,
    input  logic                        tr_pkt_yumi_i,
    input  logic [EntryWidth-1:0]       tr_resp_i,
    input  logic                        tr_resp_v_i,
    output logic                        tr_resp_ready_o,
    output logic                        done_o,
    output logic                        error_o,
    output logic                        mismatch_o,
    output logic [15:0]                 mismatch_count_o
);

    typedef enum logic [2:0] {
        StIdle, StFetch, StSend, StWaitResp, StDelay, StDone, StError
    } state_e;

    localparam logic [3:0] CmdLoad   = 4'd0;
    localparam logic [3:0] CmdStore  = 4'd1;
    localparam logic [3:0] CmdWait   = 4'd2;
    localparam logic [3:0] CmdFinish = 4'd15;

    state_e                      state_q, state_d;
    logic [rom_addr_width_p-1:0] ptr_q, ptr_d;
    logic [EntryWidth-1:0]       pkt_q, pkt_d;
    logic [15:0]                 delay_q, delay_d;
    logic                        mismatch_q, mismatch_d;
    logic [15:0]                 mcount_q, mcount_d;

    logic [3:0] rom_cmd;
    logic [3:0] pkt_cmd;
    logic       ptr_last;
    logic       timeout_hit;

    assign rom_cmd  = rom_data_i[EntryWidth-1 -: 4];
    assign pkt_cmd  = pkt_q[EntryWidth-1 -: 4];
    assign ptr_last = &ptr_q;

`ifdef BP_ME_TR_DRIVER_TIMEOUT_EN
    localparam int unsigned ToWidth = $clog2(timeout_cycles_p + 1);

    logic [ToWidth-1:0] to_q, to_d;

    // Counter is cumulative over SEND and WAIT_RESP; it only clears when SEND is entered.
    always_comb begin
        to_d = to_q;
        if (state_q == StFetch) begin
            to_d = '0;
        end else if (state_q == StSend || state_q == StWaitResp) begin
            to_d = to_q + 1'b1;
        end
    end

    assign timeout_hit = (to_q == ToWidth'(timeout_cycles_p - 1));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            to_q <= '0;
        end else begin
            to_q <= to_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = |timeout_cycles_p;
    assign timeout_hit    = 1'b0;
`endif

    logic unused_resp;
    assign unused_resp = ^tr_resp_i[EntryWidth-1:dword_width_p];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            pkt_q      <= '0;
            delay_q    <= '0;
            mismatch_q <= 1'b0;
            mcount_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            pkt_q      <= pkt_d;
            delay_q    <= delay_d;
            mismatch_q <= mismatch_d;
            mcount_q   <= mcount_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        pkt_d      = pkt_q;
        delay_d    = delay_q;
        mismatch_d = mismatch_q;
        mcount_d   = mcount_q;
        case (state_q)
            StIdle: begin
                ptr_d = '0;
                if (en_i) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                case (rom_cmd)
                    CmdLoad, CmdStore: begin
                        pkt_d   = rom_data_i;
                        state_d = StSend;
                    end
                    CmdWait: begin
                        delay_d = rom_data_i[15:0];
                        state_d = StDelay;
                    end
                    CmdFinish: state_d = StDone;
                    default:   state_d = StError;
                endcase
            end
            StSend: begin
                // A handshake in the same cycle as the timeout wins.
                if (tr_pkt_yumi_i) begin
                    state_d = StWaitResp;
                end else if (timeout_hit) begin
                    state_d = StError;
                end
            end
            StWaitResp: begin
                if (tr_resp_v_i) begin
                    if (pkt_cmd == CmdLoad
                        && tr_resp_i[dword_width_p-1:0] != pkt_q[dword_width_p-1:0]) begin
                        mismatch_d = 1'b1;
                        if (mcount_q != 16'hFFFF) begin
                            mcount_d = mcount_q + 16'd1;
                        end
                    end
                    if (ptr_last) begin
                        state_d = StError;
                    end else begin
                        ptr_d   = ptr_q + 1'b1;
                        state_d = StFetch;
                    end
                end else if (timeout_hit) begin
                    state_d = StError;
                end
            end
            StDelay: begin
                if (delay_q == 16'd0) begin
                    if (ptr_last) begin
                        state_d = StError;
                    end else begin
                        ptr_d   = ptr_q + 1'b1;
                        state_d = StFetch;
                    end
                end else begin
                    delay_d = delay_q - 16'd1;
                end
            end
            StDone:  state_d = StDone;
            StError: state_d = StError;
            default: state_d = StError;
        endcase
    end

    always_comb begin
        tr_pkt_v_o      = (state_q == StSend);
        tr_resp_ready_o = (state_q == StWaitResp);
        done_o          = (state_q == StDone);
        error_o         = (state_q == StError);
    end

    assign rom_addr_o       = ptr_q;
    assign tr_pkt_o         = pkt_q;
    assign mismatch_o       = mismatch_q;
    assign mismatch_count_o = mcount_q;

endmodule

// File: tb/tb_bp_me_nonsynth_lce_tr_driver.sv
// Directed bench for the trace-replay driver: ROM model, auto-responding LCE, immediate assertions.
module tb_bp_me_nonsynth_lce_tr_driver;

    localparam int unsigned PW = 40;
    localparam int unsigned DW = 64;
    localparam int unsigned AW = 4;
    localparam int unsigned E  = 5 + PW + DW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          en;
    logic [AW-1:0] rom_addr;
    logic [E-1:0]  rom_data;
    logic [E-1:0]  pkt;
    logic          pkt_v;
    logic          yumi;
    logic [E-1:0]  resp;
    logic          resp_v;
    logic          resp_ready;
    logic          done;
    logic          error;
    logic          mismatch;
    logic [15:0]   mcount;

    logic [E-1:0]  rom [16];
    logic          auto_yumi;
    logic          auto_resp;
    logic          resp_force;
    logic [DW-1:0] resp_data;
    logic          cnt_clr;
    int            pkt_cnt;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];
    assign yumi     = auto_yumi & pkt_v;
    assign resp_v   = resp_force | (auto_resp & resp_ready);
    assign resp     = {{(E - DW){1'b0}}, resp_data};

    always @(posedge clk) begin
        if (cnt_clr) pkt_cnt <= 0;
        else if (pkt_v && yumi) pkt_cnt <= pkt_cnt + 1;
    end

    bp_me_nonsynth_lce_tr_driver #(
        .paddr_width_p    (PW),
        .dword_width_p    (DW),
        .rom_addr_width_p (AW),
        .timeout_cycles_p (16)
    ) dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n),
        .en_i             (en),
        .rom_addr_o       (rom_addr),
        .rom_data_i       (rom_data),
        .tr_pkt_o         (pkt),
        .tr_pkt_v_o       (pkt_v),
        .tr_pkt_yumi_i    (yumi),
        .tr_resp_i        (resp),
        .tr_resp_v_i      (resp_v),
        .tr_resp_ready_o  (resp_ready),
        .done_o           (done),
        .error_o          (error),
        .mismatch_o       (mismatch),
        .mismatch_count_o (mcount)
    );

    function automatic logic [E-1:0] mk(input logic [3:0] c, input logic [PW-1:0] a,
                                        input logic [DW-1:0] d);
        return {c, 1'b0, a, d};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic fill_rom(input logic [E-1:0] v);
        for (int i = 0; i < 16; i++) rom[i] = v;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        en      = 1'b0;
        cnt_clr = 1'b1;
        cyc(2);
        reset_n = 1'b1;
        cyc(1);
        cnt_clr = 1'b0;
    endtask

    // After this returns, the edge that sampled en_i has passed (state is FETCH).
    task automatic start();
        en = 1'b1;
        cyc(1);
        en = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        en         = 1'b0;
        auto_yumi  = 1'b1;
        auto_resp  = 1'b1;
        resp_force = 1'b0;
        resp_data  = '0;
        cnt_clr    = 1'b1;
        fill_rom(mk(4'd15, '0, '0));

        // Single load, matching response
        rom[0]    = mk(4'd0, 40'h1000, 64'hAB);
        resp_data = 64'hAB;
        do_reset();
        chk("rst_v", pkt_v, 0);
        chk("rst_ready", resp_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_mismatch", mismatch, 0);
        chk("rst_mcount", mcount, 0);
        chk("rst_pkt", pkt, 0);
        chk("rst_addr", rom_addr, 0);
        start();
        chk("t1_fetch_v", pkt_v, 0);
        cyc(1);
        chk("t1_send_v", pkt_v, 1);
        chk("t1_send_pkt", pkt, mk(4'd0, 40'h1000, 64'hAB));
        cyc(1);
        chk("t1_wait_ready", resp_ready, 1);
        chk("t1_wait_v", pkt_v, 0);
        cyc(1);
        chk("t1_fetch2_addr", rom_addr, 1);
        cyc(1);
        chk("t1_done", done, 1);
        chk("t1_mcount", mcount, 0);
        chk("t1_mismatch", mismatch, 0);
        chk("t1_pkt_cnt", pkt_cnt, 1);
        en = 1'b1;
        cyc(3);
        en = 1'b0;
        chk("t1_done_sticky", done, 1);
        chk("t1_done_no_v", pkt_v, 0);

        // Load mismatch, then a store whose differing response data is ignored
        fill_rom(mk(4'd15, '0, '0));
        rom[0]    = mk(4'd0, 40'h1000, 64'hAB);
        rom[1]    = mk(4'd1, 40'h2000, 64'h55);
        resp_data = 64'hAC;
        do_reset();
        start();
        cyc(1);
        chk("t2_send1_v", pkt_v, 1);
        cyc(1);
        chk("t2_wait_v", pkt_v, 0);
        cyc(1);
        chk("t2_fetch_v", pkt_v, 0);
        chk("t2_mismatch", mismatch, 1);
        chk("t2_mcount1", mcount, 1);
        cyc(1);
        chk("t2_send2_v_latency3", pkt_v, 1);
        chk("t2_send2_pkt", pkt, mk(4'd1, 40'h2000, 64'h55));
        cyc(3);
        chk("t2_done", done, 1);
        chk("t2_mcount_final", mcount, 1);
        chk("t2_mismatch_final", mismatch, 1);

        // Wait 5 spends six DELAY cycles
        fill_rom(mk(4'd15, '0, '0));
        rom[0]    = mk(4'd2, '0, 64'd5);
        rom[1]    = mk(4'd1, 40'h2000, 64'h77);
        resp_data = '0;
        do_reset();
        start();
        cyc(6);
        chk("t3_delay_addr", rom_addr, 0);
        chk("t3_delay_v", pkt_v, 0);
        cyc(1);
        chk("t3_fetch_addr", rom_addr, 1);
        chk("t3_fetch_v", pkt_v, 0);
        cyc(1);
        chk("t3_send_v", pkt_v, 1);

        // Wait-0 entries across the whole ROM: one DELAY cycle each, then overrun
        fill_rom(mk(4'd2, '0, '0));
        do_reset();
        start();
        cyc(2);
        chk("t4_wait0_addr", rom_addr, 1);
        cyc(29);
        chk("t4_last_addr", rom_addr, 15);
        chk("t4_pre_error", error, 0);
        cyc(1);
        chk("t4_overrun_error", error, 1);
        chk("t4_overrun_addr", rom_addr, 15);
        chk("t4_overrun_done", done, 0);

        // Bad opcode
        fill_rom(mk(4'd15, '0, '0));
        rom[0] = mk(4'd7, 40'h1000, 64'h1);
        do_reset();
        start();
        chk("t5_fetch_error", error, 0);
        cyc(1);
        chk("t5_error", error, 1);
        chk("t5_v", pkt_v, 0);
        en = 1'b1;
        cyc(3);
        en = 1'b0;
        chk("t5_error_sticky", error, 1);
        chk("t5_done", done, 0);
        chk("t5_v_never", pkt_v, 0);

        // LCE never consumes the packet
        fill_rom(mk(4'd15, '0, '0));
        rom[0]    = mk(4'd1, 40'h2000, 64'h99);
        auto_yumi = 1'b0;
        do_reset();
        start();
`ifdef BP_ME_TR_DRIVER_TIMEOUT_EN
        cyc(16);
        chk("t6_send_v", pkt_v, 1);
        chk("t6_pre_timeout", error, 0);
        cyc(1);
        chk("t6_timeout_error", error, 1);
        chk("t6_timeout_v", pkt_v, 0);
`else
        cyc(1000);
        chk("t6_held_v", pkt_v, 1);
        chk("t6_no_error", error, 0);
        chk("t6_held_pkt", pkt, mk(4'd1, 40'h2000, 64'h99));
`endif

        // Reset during WAIT_RESP
        fill_rom(mk(4'd15, '0, '0));
        rom[0]    = mk(4'd0, 40'h3000, 64'h11);
        auto_yumi = 1'b1;
        auto_resp = 1'b0;
        do_reset();
        start();
        cyc(2);
        chk("t7_wait_ready", resp_ready, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t7_rst_ready", resp_ready, 0);
        chk("t7_rst_v", pkt_v, 0);
        chk("t7_rst_pkt", pkt, 0);
        chk("t7_rst_done", done, 0);
        chk("t7_rst_error", error, 0);
        @(negedge clk);
        reset_n    = 1'b1;
        resp_force = 1'b1;
        resp_data  = 64'h99;
        cyc(3);
        chk("t7_late_resp_ready", resp_ready, 0);
        chk("t7_late_resp_v", pkt_v, 0);
        chk("t7_late_resp_mismatch", mismatch, 0);
        chk("t7_idle_addr", rom_addr, 0);
        resp_force = 1'b0;
        auto_resp  = 1'b1;
        resp_data  = 64'h11;
        cnt_clr    = 1'b1;
        cyc(1);
        cnt_clr = 1'b0;
        start();
        chk("t7_restart_addr", rom_addr, 0);
        cyc(1);
        chk("t7_restart_v", pkt_v, 1);
        chk("t7_restart_pkt", pkt, mk(4'd0, 40'h3000, 64'h11));
        cyc(3);
        chk("t7_restart_done", done, 1);
        chk("t7_restart_mcount", mcount, 0);
        chk("t7_restart_pkt_cnt", pkt_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
